uart_rx_frame: RTL and testbench

//  Standalone UART receiver: deserialises the 8-bit LSB-first frames produced by the

---
 rtl/uart_rx_frame.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling of start/8 data/optional parity/stop,
// single-entry holding register with valid/ready handoff plus parity, framing and overrun status.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s low
// S_START | timing half a bit to confirm start bit (high -> glitch, drop)
// S_DATA  | sampling 8 data bits LSB first, one per bit period
// S_PAR   | sampling parity bit (only when PARITY != 0)
// S_STOP  | sampling stop bit; frame completes on the sample
module uart_rx_frame #(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200,
   parameter int PARITY = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun
);

   localparam int BIT_CYC  = CLK_HZ / BAUD;
   localparam int HALF_CYC = BIT_CYC / 2;
   localparam int CW       = $clog2(BIT_CYC) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   state_t        state, state_nxt;
   logic          rx_meta, rx_s;
   logic [CW-1:0] cnt;
   logic          tick;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          par_bad;
   logic          stop_bad;
   logic          done;

   logic          start_load;
   logic          data_smp;
   logic          par_smp;
   logic          stop_smp;

   assign tick = (cnt == '0);

   // reset level is high on this codebase's rst_n
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!rx_s) state_nxt = S_START;
         S_START: if (tick) state_nxt = rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (tick && bit_idx == 3'd7) state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
         S_PAR:   if (tick) state_nxt = S_STOP;
         S_STOP:  if (tick) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      start_load = 1'b0;
      data_smp   = 1'b0;
      par_smp    = 1'b0;
      stop_smp   = 1'b0;
      case (state)
         S_IDLE:  start_load = !rx_s;
         S_DATA:  data_smp   = tick;
         S_PAR:   par_smp    = tick;
         S_STOP:  stop_smp   = tick;
         default: ;
      endcase
   end

   // bit timer: down-counter, samples taken at terminal count
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         cnt <= '0;
      end else if (state == S_IDLE) begin
         cnt <= start_load ? CW'(HALF_CYC - 1) : '0;
      end else if (tick) begin
         cnt <= CW'(BIT_CYC - 1);
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         bit_idx  <= '0;
         shreg    <= '0;
         par_bad  <= 1'b0;
         stop_bad <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= stop_smp;
         if (state == S_START && tick) begin
            bit_idx <= '0;
            par_bad <= 1'b0;
         end
         if (data_smp) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (par_smp) begin
            if (PARITY == 1) par_bad <= ~(^{shreg, rx_s});
            else             par_bad <= ^{shreg, rx_s};
         end
         if (stop_smp) stop_bad <= ~rx_s;
      end
   end

   // holding register: a simultaneous accept frees the slot for the new frame
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done) begin
            if (!rx_valid || rx_ready) begin
               rx_data    <= shreg;
               parity_err <= par_bad;
               frame_err  <= stop_bad;
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: three instances (no parity at default baud, odd and
// even parity at a fast baud); expected bytes/flags are queued at send time, popped by a monitor.
module tb_uart_rx_frame;

   logic       clk;
   logic       rst_n;
   logic       rx         [3];
   logic       rx_ready   [3];
   logic [7:0] rx_data    [3];
   logic       rx_valid   [3];
   logic       parity_err [3];
   logic       frame_err  [3];
   logic       overrun    [3];

   int n_cmp = 0;
   int n_bad = 0;

   logic [9:0] q0[$];
   logic [9:0] q1[$];
   logic [9:0] q2[$];
   logic       held    [3];
   int         ovr_exp [3];
   int         ovr_seen[3];
   logic       ovr_prev[3];

   uart_rx_frame #(.CLK_HZ(50_000_000), .BAUD(115200), .PARITY(0)) u0 (
      .clk(clk), .rst_n(rst_n), .rx(rx[0]), .rx_ready(rx_ready[0]), .rx_data(rx_data[0]),
      .rx_valid(rx_valid[0]), .parity_err(parity_err[0]), .frame_err(frame_err[0]),
      .overrun(overrun[0]));
   uart_rx_frame #(.CLK_HZ(50_000_000), .BAUD(3_125_000), .PARITY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .rx(rx[1]), .rx_ready(rx_ready[1]), .rx_data(rx_data[1]),
      .rx_valid(rx_valid[1]), .parity_err(parity_err[1]), .frame_err(frame_err[1]),
      .overrun(overrun[1]));
   uart_rx_frame #(.CLK_HZ(50_000_000), .BAUD(3_125_000), .PARITY(2)) u2 (
      .clk(clk), .rst_n(rst_n), .rx(rx[2]), .rx_ready(rx_ready[2]), .rx_data(rx_data[2]),
      .rx_valid(rx_valid[2]), .parity_err(parity_err[2]), .frame_err(frame_err[2]),
      .overrun(overrun[2]));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic int bit_t(input int u);
      return (u == 0) ? 434 * 20 : 16 * 20;
   endfunction

   function automatic int qsize(input int u);
      case (u)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [9:0] qpop(input int u);
      case (u)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   function automatic void qpush(input int u, input logic [9:0] v);
      case (u)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference: byte as sent, parity check from the line bit, framing from the stop bit
   task automatic send_frame(input int u, input logic [7:0] d, input logic p, input logic stop);
      int   bt;
      logic pe;
      bt = bit_t(u);
      pe = 1'b0;
      if (u == 1) pe = ((^d) ^ p) != 1'b1;
      if (u == 2) pe = ((^d) ^ p) != 1'b0;
      if (!rx_ready[u] && held[u]) begin
         ovr_exp[u]++;
      end else begin
         qpush(u, {pe, ~stop, d});
         if (!rx_ready[u]) held[u] = 1'b1;
      end
      rx[u] = 1'b0;
      #(bt);
      for (int i = 0; i < 8; i++) begin
         rx[u] = d[i];
         #(bt);
      end
      if (u != 0) begin
         rx[u] = p;
         #(bt);
      end
      rx[u] = stop;
      if (stop) begin
         #(bt);
      end else begin
         #(bt * 3 / 4);
         rx[u] = 1'b1;
         #(bt / 4);
      end
      rx[u] = 1'b1;
   endtask

   task automatic wait_drain(input int u, input string name);
      for (int i = 0; i < 2000; i++) begin
         if (qsize(u) == 0 && !rx_valid[u]) break;
         @(negedge clk);
      end
      chk(name, qsize(u), 0);
   endtask

   task automatic set_ready(input int u, input logic v);
      @(posedge clk);
      #1 rx_ready[u] = v;
   endtask

   always @(negedge clk) begin
      logic [9:0] e;
      if (!rst_n) begin
         for (int u = 0; u < 3; u++) begin
            if (rx_valid[u] && rx_ready[u]) begin
               if (qsize(u) == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_byte u%0d: got %0h expected none at %0t",
                           u, rx_data[u], $time);
               end else begin
                  e = qpop(u);
                  held[u] = 1'b0;
                  chk($sformatf("data_u%0d", u), {24'd0, rx_data[u]}, {24'd0, e[7:0]});
                  chk($sformatf("frame_err_u%0d", u), {31'd0, frame_err[u]}, {31'd0, e[8]});
                  chk($sformatf("parity_err_u%0d", u), {31'd0, parity_err[u]}, {31'd0, e[9]});
               end
            end
            if (overrun[u]) begin
               ovr_seen[u]++;
               if (ovr_prev[u]) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL overrun_width u%0d: got 2+ cycles expected 1", u);
               end
            end
            ovr_prev[u] = overrun[u];
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       p;
      for (int u = 0; u < 3; u++) begin
         rx[u]       = 1'b1;
         rx_ready[u] = 1'b1;
         held[u]     = 1'b0;
         ovr_exp[u]  = 0;
         ovr_seen[u] = 0;
         ovr_prev[u] = 1'b0;
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         chk($sformatf("rst_data_u%0d", u), {24'd0, rx_data[u]}, 32'h0);
         chk($sformatf("rst_valid_u%0d", u), {31'd0, rx_valid[u]}, 32'h0);
         chk($sformatf("rst_flags_u%0d", u),
             {29'd0, parity_err[u], frame_err[u], overrun[u]}, 32'h0);
      end
      rst_n = 1'b0;
      repeat (5) @(negedge clk);

      // plain byte, no parity
      send_frame(0, 8'hA5, 1'b0, 1'b1);
      wait_drain(0, "drain_a5");

      // odd parity: clean then bad parity bit
      send_frame(1, 8'h03, 1'b1, 1'b1);
      send_frame(1, 8'h03, 1'b0, 1'b1);
      wait_drain(1, "drain_odd");

      // even parity: clean then bad stop bit
      send_frame(2, 8'h03, 1'b0, 1'b1);
      send_frame(2, 8'h03, 1'b0, 1'b0);
      wait_drain(2, "drain_even");

      // backpressure: second frame dropped with a single overrun pulse
      set_ready(0, 1'b0);
      send_frame(0, 8'h11, 1'b0, 1'b1);
      send_frame(0, 8'h22, 1'b0, 1'b1);
      repeat (50) @(negedge clk);
      chk("held_valid", {31'd0, rx_valid[0]}, 32'h1);
      chk("held_data", {24'd0, rx_data[0]}, 32'h11);
      chk("overrun_count", ovr_seen[0], 1);
      set_ready(0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk("valid_fall", {31'd0, rx_valid[0]}, 32'h0);
      chk("data_kept", {24'd0, rx_data[0]}, 32'h11);
      wait_drain(0, "drain_ovr");

      // short low glitch while idle
      rx[0] = 1'b0;
      #2000;
      rx[0] = 1'b1;
      for (int i = 0; i < 12 * 434; i++) begin
         @(negedge clk);
         if (rx_valid[0]) break;
      end
      chk("glitch_no_valid", {31'd0, rx_valid[0]}, 32'h0);

      // reset in the middle of the data bits of 8'hFF
      rx[0] = 1'b0;
      #(bit_t(0));
      rx[0] = 1'b1;
      #(bit_t(0) * 3);
      rst_n = 1'b1;
      #200;
      @(negedge clk);
      chk("midrst_valid", {31'd0, rx_valid[0]}, 32'h0);
      chk("midrst_data", {24'd0, rx_data[0]}, 32'h0);
      rst_n = 1'b0;
      repeat (20) @(negedge clk);
      send_frame(0, 8'h5A, 1'b0, 1'b1);
      wait_drain(0, "drain_5a");

      // back-to-back random traffic on the parity instances
      fork
         begin
            for (int k = 0; k < 12; k++) begin
               d = 8'($urandom);
               p = 1'($urandom);
               send_frame(1, d, p, 1'b1);
            end
         end
         begin
            logic [7:0] d2;
            for (int k = 0; k < 20; k++) begin
               d2 = 8'($urandom);
               send_frame(2, d2, ^d2, 1'b1);
            end
         end
      join
      wait_drain(1, "drain_rand_odd");
      wait_drain(2, "drain_rand_even");

      for (int u = 0; u < 3; u++)
         chk($sformatf("overrun_total_u%0d", u), ovr_seen[u], ovr_exp[u]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
